// File: rtl/uart_pkg.sv
// Shared register map, status bit positions and FSM encoding for the UART TX controller.
package uart_pkg;

    localparam logic [7:0] OFF_TX_DATA  = 8'h04;
    localparam logic [7:0] OFF_STAT     = 8'h08;
    localparam logic [7:0] OFF_TX_CNT   = 8'h14;
    localparam logic [7:0] OFF_IRQ_EN   = 8'h18;
    localparam logic [7:0] OFF_TX_WMARK = 8'h1C;

    localparam int STAT_EMPTY  = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_ACTIVE = 2;
    localparam int STAT_DONE   = 3;
    localparam int STAT_OVF    = 4;
    localparam int STAT_WMARK  = 5;

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} tx_state_e;

    // Decoded bus access, qualified to the ack cycle.
    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [7:0] off;
    } wb_acc_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with first-word-fall-through output and occupancy count.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_en,
    input  logic                     r_en,
    input  logic [W-1:0]             data_in,
    output logic [W-1:0]             data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr, rd;

    assign full     = (cnt == (AW+1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign wr       = w_en & ~full;
    assign rd       = r_en & ~empty;
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Wishbone UART TX controller: FIFO-fed start/handshake FSM, status/count regs, drain IRQ.
// Define UART_TX_WMARK_IRQ_EN to add the TX_WMARK register and low-watermark interrupt source.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int          DEPTH         = 8,
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int          START_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wb_valid,
    input  logic [31:0] i_wb_adr,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_dat,
    output logic [7:0]  o_tx,
    output logic        o_tx_start,
    input  logic        i_tx_start_clear,
    input  logic        i_tx_busy,
    output logic        o_irq
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(START_TIMEOUT + 1);

    wb_acc_t       acc;
    logic          in_win;
    tx_state_e     state_q, state_d;
    logic [7:0]    tx_d, fifo_dout;
    logic          start_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pop, push, push_req, full, empty;
    logic [CW-1:0] cnt, wmark_rd;
    logic          done_set, to_set, ovf_set, stat_rd;
    logic          done_pend, ovf_pend, wm_bit, irq_en, irq_src;
    logic [31:0]   stat;
    logic          unused_bits;

    // Side effects are tied to the ack cycle, so the master's address is still stable here.
    assign in_win  = (i_wb_adr[31:8] == BASE_ADDR[31:8]);
    assign acc.off = i_wb_adr[7:0];
    assign acc.wr  = o_wb_ack & i_wb_valid & in_win & i_wb_we;
    assign acc.rd  = o_wb_ack & i_wb_valid & in_win & ~i_wb_we;

    assign push_req = acc.wr & (acc.off == OFF_TX_DATA) & i_wb_sel[0];
    assign push     = push_req & ~full;
    assign ovf_set  = (push_req & full) | to_set;
    assign stat_rd  = acc.rd & (acc.off == OFF_STAT);

    uart_tx_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .w_en     (push),
        .r_en     (pop),
        .data_in  (i_wb_dat[7:0]),
        .data_out (fifo_dout),
        .full     (full),
        .empty    (empty),
        .cnt      (cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            o_tx       <= '0;
            o_tx_start <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            o_tx       <= tx_d;
            o_tx_start <= start_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tx_d     = o_tx;
        start_d  = o_tx_start;
        timer_d  = timer_q;
        pop      = 1'b0;
        done_set = 1'b0;
        to_set   = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                tx_d    = fifo_dout;
                start_d = 1'b1;
                timer_d = '0;
                state_d = START;
            end
            START: if (i_tx_start_clear || i_tx_busy) begin
                start_d = 1'b0;
                state_d = BUSY;
            end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
                // Transmitter never answered: the byte is abandoned and flagged as overflow.
                start_d = 1'b0;
                to_set  = 1'b1;
                state_d = IDLE;
            end else begin
                timer_d = timer_q + TW'(1);
            end
            BUSY: if (!i_tx_busy) state_d = DONE;
            DONE: begin
                done_set = empty;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_TX_WMARK_IRQ_EN
    logic [CW-1:0] wmark, cnt_nxt;
    logic          wm_pend, wm_set;

    assign cnt_nxt = cnt + CW'(push) - CW'(pop);
    assign wm_set  = (cnt > wmark) && (cnt_nxt <= wmark);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wmark   <= '0;
            wm_pend <= 1'b0;
        end else begin
            if (acc.wr && acc.off == OFF_TX_WMARK) wmark <= i_wb_dat[CW-1:0];
            wm_pend <= wm_set | (wm_pend & ~stat_rd);
        end
    end

    assign wm_bit   = wm_pend;
    assign wmark_rd = wmark;
`else
    assign wm_bit   = 1'b0;
    assign wmark_rd = '0;
`endif

    assign irq_src = done_pend | wm_bit;

    // Set events take priority over the read-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_wb_ack  <= 1'b0;
            done_pend <= 1'b0;
            ovf_pend  <= 1'b0;
            irq_en    <= 1'b0;
            o_irq     <= 1'b0;
        end else begin
            o_wb_ack  <= i_wb_valid & ~o_wb_ack;
            done_pend <= done_set | (done_pend & ~stat_rd);
            ovf_pend  <= ovf_set | (ovf_pend & ~stat_rd);
            if (acc.wr && acc.off == OFF_IRQ_EN) irq_en <= i_wb_dat[0];
            o_irq     <= irq_src & irq_en;
        end
    end

    always_comb begin
        stat               = '0;
        stat[STAT_EMPTY]   = empty;
        stat[STAT_FULL]    = full;
        stat[STAT_ACTIVE]  = (state_q != IDLE) | i_tx_busy;
        stat[STAT_DONE]    = done_pend;
        stat[STAT_OVF]     = ovf_pend;
        stat[STAT_WMARK]   = wm_bit;
    end

    always_comb begin
        o_wb_dat = '0;
        if (o_wb_ack && in_win) begin
            case (acc.off)
                OFF_STAT:     o_wb_dat = stat;
                OFF_TX_CNT:   o_wb_dat[CW-1:0] = cnt;
                OFF_IRQ_EN:   o_wb_dat[0] = irq_en;
                OFF_TX_WMARK: o_wb_dat[CW-1:0] = wmark_rd;
                default:      ;
            endcase
        end
    end

    assign unused_bits = &{1'b0, i_wb_dat, i_wb_sel};

endmodule
